// File: rtl/masked_shfrot_initiator.sv
//------------------------------------------------------------------------------
// Module   : masked_shfrot_initiator
// Brief    : Request-side initiator for the two-share masked shift/rotate unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module masked_shfrot_initiator #(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [4:0]           req_shamt,
    input  logic [BIT_WIDTH-1:0] req_s0,
    input  logic [BIT_WIDTH-1:0] req_s1,
    input  logic [BIT_WIDTH-1:0] rnd_mask,
    input  logic [BIT_WIDTH-1:0] rnd_pad,
    output logic                 srli,
    output logic                 slli,
    output logic                 rori,
    output logic                 ena,
    output logic [4:0]           shamt,
    output logic [BIT_WIDTH-1:0] s0,
    output logic [BIT_WIDTH-1:0] s1,
    output logic [BIT_WIDTH-1:0] rp0,
    input  logic [BIT_WIDTH-1:0] r0,
    input  logic [BIT_WIDTH-1:0] r1,
    input  logic                 core_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_r0,
    output logic [BIT_WIDTH-1:0] rsp_r1,
    output logic                 rsp_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    localparam logic [1:0] OP_SRLI    = 2'd0;
    localparam logic [1:0] OP_SLLI    = 2'd1;
    localparam logic [1:0] OP_RORI    = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [3:0] C_TIMEOUT  = 4'(TIMEOUT);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_cnt;
    logic       w_illegal;
    logic       w_timeout;

    assign w_illegal = (req_op == OP_ILLEGAL);
    // Compare the post-increment value so ena stays high exactly TIMEOUT cycles.
    assign w_timeout = ((r_cnt + 4'd1) == C_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = w_illegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_ready || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decode the state only, so no input feeds req_ready.
    always_comb begin
        req_ready = (r_state == ST_IDLE);
        ena       = (r_state == ST_ISSUE);
        rsp_valid = (r_state == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0      <= '0;
            s1      <= '0;
            rp0     <= '0;
            shamt   <= '0;
            srli    <= 1'b0;
            slli    <= 1'b0;
            rori    <= 1'b0;
            r_cnt   <= '0;
            rsp_r0  <= '0;
            rsp_r1  <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        s0      <= req_s0 ^ rnd_mask;
                        s1      <= req_s1 ^ rnd_mask;
                        rp0     <= rnd_pad;
                        shamt   <= req_shamt;
                        srli    <= (req_op == OP_SRLI);
                        slli    <= (req_op == OP_SLLI);
                        rori    <= (req_op == OP_RORI);
                        r_cnt   <= '0;
                        rsp_r0  <= '0;
                        rsp_r1  <= '0;
                        rsp_err <= w_illegal;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (core_ready) begin
                        rsp_r0  <= r0;
                        rsp_r1  <= r1;
                        rsp_err <= 1'b0;
                    end else if (w_timeout) begin
                        rsp_r0  <= '0;
                        rsp_r1  <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // Scrub every share-carrying register once the result is consumed.
                    if (rsp_ready) begin
                        s0      <= '0;
                        s1      <= '0;
                        rp0     <= '0;
                        shamt   <= '0;
                        srli    <= 1'b0;
                        slli    <= 1'b0;
                        rori    <= 1'b0;
                        rsp_r0  <= '0;
                        rsp_r1  <= '0;
                        rsp_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
